// File: rtl/ofmap_packetizer.sv
// Converts output-spike / row-end events into 64-bit NoC packets via a FIFO and counts DONE pops per timestep.
// Optional statistics outputs are built when OFMAP_PACKETIZER_STATS_EN is defined.
module ofmap_packetizer #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned SRC_ADDR     = 9,
   parameter int unsigned DST_ADDR     = 0,
   parameter int unsigned OFMAP_DIM    = 21,
   parameter int unsigned DONES_PER_TS = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_x,
   input  logic [4:0]  in_y,
   input  logic        in_fire,
   input  logic        in_last,
   output logic        pkt_valid,
   input  logic        pkt_ready,
   output logic [63:0] pkt_data,
   output logic [7:0]  ts_count,
`ifdef OFMAP_PACKETIZER_STATS_EN
   output logic [15:0] stat_spikes,
   output logic [15:0] stat_drops,
`endif
   output logic        err_range
);

   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam logic [63:0] HDR       = {4'(SRC_ADDR), 4'(DST_ADDR), 2'b11, 54'd0};
   localparam logic [9:0]  DONE_CODE = 10'h1FF;
   localparam logic [5:0]  DIM       = 6'(OFMAP_DIM);
   localparam logic [AW:0] READY_MAX = (AW+1)'(FIFO_DEPTH - 2);
   localparam logic [7:0]  DONE_LAST = 8'(DONES_PER_TS - 1);

   typedef enum logic {COUNT, ROLL} tsState_t;

   logic [63:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] rdPtr, wrPtr, wrPtrNext1;
   logic [AW:0]   occ, occNext;
   logic [1:0]    numPush;
   logic          accept, inRange, pushSpike, pushDone, dropSpike;
   logic          pop, headDone, popDone, popSpike;
   logic [7:0]    doneCnt;
   tsState_t      state, stateNext;

   assign accept     = in_valid & in_ready;
   assign inRange    = ({1'b0, in_x} < DIM) & ({1'b0, in_y} < DIM);
   assign pushSpike  = accept & in_fire & inRange;
   assign dropSpike  = accept & in_fire & ~inRange;
   assign pushDone   = accept & in_last;
   assign numPush    = {1'b0, pushSpike} + {1'b0, pushDone};
   assign wrPtrNext1 = wrPtr + AW'(1);

   assign pkt_valid = (occ != '0);
   assign pkt_data  = pkt_valid ? mem[rdPtr] : '0;
   assign pop       = pkt_valid & pkt_ready;
   assign headDone  = (pkt_data[9:0] == DONE_CODE);
   assign popDone   = pop & headDone;
   assign popSpike  = pop & ~headDone;
   assign occNext   = occ + (AW+1)'(numPush) - (AW+1)'(pop);

   // DONE lands in the slot after the spike when both are written together
   always_ff @(posedge clk) begin
      if (pushSpike) mem[wrPtr] <= HDR | {54'd0, in_x, in_y};
      if (pushDone)  mem[pushSpike ? wrPtrNext1 : wrPtr] <= HDR | {54'd0, DONE_CODE};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         occ       <= '0;
         in_ready  <= 1'b0;
         err_range <= 1'b0;
      end else begin
         wrPtr    <= wrPtr + AW'(numPush);
         rdPtr    <= rdPtr + AW'(pop);
         occ      <= occNext;
         in_ready <= (occNext <= READY_MAX);
         if (dropSpike) err_range <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COUNT;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         COUNT:   if (popDone && doneCnt == DONE_LAST) stateNext = ROLL;
         ROLL:    stateNext = COUNT;
         default: stateNext = COUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doneCnt  <= '0;
         ts_count <= '0;
      end else if (state == ROLL) begin
         doneCnt  <= {7'd0, popDone};
         ts_count <= ts_count + 8'd1;
      end else if (popDone) begin
         doneCnt  <= doneCnt + 8'd1;
      end
   end

`ifdef OFMAP_PACKETIZER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_spikes <= '0;
         stat_drops  <= '0;
      end else if (state == ROLL) begin
         stat_spikes <= {15'd0, popSpike};
         stat_drops  <= {15'd0, dropSpike};
      end else begin
         if (popSpike && stat_spikes != '1) stat_spikes <= stat_spikes + 16'd1;
         if (dropSpike && stat_drops != '1) stat_drops <= stat_drops + 16'd1;
      end
   end
`else
   // statistics counters not built
`endif

endmodule

// File: tb/tb_ofmap_packetizer.sv
// Directed bench for ofmap_packetizer: expected packets queued at drive time, checked on each pop.
module tb_ofmap_packetizer;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_fire, in_last;
   logic [4:0]  in_x, in_y;
   logic        pkt_valid, pkt_ready, err_range;
   logic [63:0] pkt_data;
   logic [7:0]  ts_count;
`ifdef OFMAP_PACKETIZER_STATS_EN
   logic [15:0] stat_spikes, stat_drops;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [63:0] expQ[$];

   localparam logic [63:0] DONE_PKT = 64'h90C0_0000_0000_01FF;

   ofmap_packetizer #(.FIFO_DEPTH(8), .SRC_ADDR(9), .DST_ADDR(0), .OFMAP_DIM(21), .DONES_PER_TS(7)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_fire(in_fire), .in_last(in_last),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
      .ts_count(ts_count),
`ifdef OFMAP_PACKETIZER_STATS_EN
      .stat_spikes(stat_spikes), .stat_drops(stat_drops),
`endif
      .err_range(err_range)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] spk(input logic [4:0] x, input logic [4:0] y);
      return {4'h9, 4'h0, 2'b11, 44'd0, x, y};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // scoreboard: every pop must match the oldest expected packet
   always @(negedge clk) begin
      if (rst_n === 1'b1 && pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
         if (expQ.size() == 0) check("unexpected_pop", pkt_data, 64'd0 - 64'd1);
         else check("pop_data", pkt_data, expQ.pop_front());
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic sendEvent(input logic [4:0] x, input logic [4:0] y, input logic f, input logic l);
      int unsigned n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; in_x = x; in_y = y; in_fire = f; in_last = l;
      if (f && x < 21 && y < 21) expQ.push_back(spk(x, y));
      if (l) expQ.push_back(DONE_PKT);
      step();
      in_valid = 1'b0; in_fire = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain(input string tag);
      int unsigned n = 0;
      while (expQ.size() != 0 && n < 100) begin step(); n++; end
      step();
      check(tag, 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      int unsigned acc;
      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_fire = 1'b0; in_last = 1'b0;
      pkt_ready = 1'b0;
      #2;
      check("rst_pkt_valid", {63'd0, pkt_valid}, 64'd0);
      check("rst_pkt_data", pkt_data, 64'd0);
      check("rst_ts_count", {56'd0, ts_count}, 64'd0);
      check("rst_err_range", {63'd0, err_range}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      step(); step();
      rst_n = 1'b1;
      step(); step();
      pkt_ready = 1'b1;

      // single spike, one-cycle latency
      sendEvent(5'd3, 5'd7, 1'b1, 1'b0);
      check("t1_valid", {63'd0, pkt_valid}, 64'd1);
      check("t1_data", pkt_data, 64'h90C0_0000_0000_0067);
      step();
      check("t1_valid_gone", {63'd0, pkt_valid}, 64'd0);

      // spike and DONE from one event
      sendEvent(5'd20, 5'd20, 1'b1, 1'b1);
      check("t2_spike", pkt_data, 64'h90C0_0000_0000_0294);
      step();
      check("t2_done", pkt_data, DONE_PKT);
      step();
      check("t2_empty", {63'd0, pkt_valid}, 64'd0);

      // null event consumes nothing
      sendEvent(5'd5, 5'd5, 1'b0, 1'b0);
      step();
      check("null_event", {63'd0, pkt_valid}, 64'd0);

      // backpressure fills to FIFO_DEPTH-1
      pkt_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (!in_ready) break;
         in_valid = 1'b1; in_fire = 1'b1; in_x = 5'(i); in_y = 5'(i + 1);
         expQ.push_back(spk(5'(i), 5'(i + 1)));
         acc++;
         step();
      end
      in_valid = 1'b0; in_fire = 1'b0;
      check("t3_accepted", 64'(acc), 64'd7);
      step(); step();
      check("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("t3_head_stable", pkt_data, spk(5'd0, 5'd1));
      pkt_ready = 1'b1;
      drain("t3_drain");

      // out-of-range spike dropped, DONE still emitted
      sendEvent(5'd21, 5'd0, 1'b1, 1'b1);
      check("t4_err", {63'd0, err_range}, 64'd1);
      check("t4_head_done", pkt_data, DONE_PKT);
      drain("t4_drain");
      step(); step();
      check("t4_err_sticky", {63'd0, err_range}, 64'd1);
`ifdef OFMAP_PACKETIZER_STATS_EN
      check("t4_stat_drops", {48'd0, stat_drops}, 64'd1);
`endif

      // two DONEs popped so far; four more, then the seventh
      for (int i = 0; i < 4; i++) sendEvent(5'd0, 5'd0, 1'b0, 1'b1);
      drain("t5_drain4");
      check("t5_ts_before", {56'd0, ts_count}, 64'd0);
      sendEvent(5'd0, 5'd0, 1'b0, 1'b1);
      step();
      check("t5_ts_roll_cycle", {56'd0, ts_count}, 64'd0);
      step();
      check("t5_ts_one", {56'd0, ts_count}, 64'd1);
      for (int i = 0; i < 7; i++) sendEvent(5'd1, 5'd1, 1'b0, 1'b1);
      drain("t5_drain7");
      step(); step();
      check("t5_ts_two", {56'd0, ts_count}, 64'd2);

      // async reset with queued, stalled packets
      pkt_ready = 1'b0;
      for (int i = 0; i < 5; i++) sendEvent(5'(i), 5'd2, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      expQ.delete();
      check("t6_valid", {63'd0, pkt_valid}, 64'd0);
      check("t6_data", pkt_data, 64'd0);
      check("t6_ts", {56'd0, ts_count}, 64'd0);
      check("t6_err", {63'd0, err_range}, 64'd0);
      step(); step();
      rst_n = 1'b1;
      pkt_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("t6_no_packet", {63'd0, pkt_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
